// File: rtl/usb_pll_supervisor.sv
// USB PLL supervisor: sequences PLL reset, qualifies lock and gates the USB domain reset.
// Optional bounded retry on lock timeout is enabled with `define PLL_SUP_RETRY_EN.
module usb_pll_supervisor #(
    parameter int PLL_RST_CYC      = 24,
    parameter int LOCK_STABLE_CYC  = 2400,
    parameter int LOCK_TIMEOUT_CYC = 240000,
    parameter int MAX_RETRY        = 3,
    parameter int CNT_W            = 8
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             lock,
    input  logic             retry_req,
    output logic             pll_reset,
    output logic             usb_rst,
    output logic             ready,
    output logic             fail,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [2:0]       state_o
);

    // state     | meaning
    // RST_PLL   | PLL RESET held high for PLL_RST_CYC cycles
    // WAIT_LOCK | waiting for synchronised lock, bounded by LOCK_TIMEOUT_CYC
    // STABLE    | lock seen, qualifying for LOCK_STABLE_CYC consecutive cycles
    // RUN       | clocks valid, USB domain released
    // FAIL      | gave up; leaves only on retry_req
    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam int MAX_A   = (PLL_RST_CYC > LOCK_STABLE_CYC) ? PLL_RST_CYC : LOCK_STABLE_CYC;
    localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYC) ? MAX_A : LOCK_TIMEOUT_CYC;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(PLL_RST_CYC - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic             lock_m;
    logic             lock_s;
    logic             loss_inc;

    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= lock;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state <= ST_RST_PLL;
        end else begin
            state <= state_nxt;
        end
    end

    // One shared timer; restarting it on any transition keeps each state's budget independent.
    always_ff @(posedge clkin) begin
        if (reset) begin
            timer <= '0;
        end else if (state_nxt != state) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            loss_cnt <= '0;
        end else if (loss_inc && (loss_cnt != {CNT_W{1'b1}})) begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end

`ifdef PLL_SUP_RETRY_EN
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    logic [3:0] retry_cnt;
    logic       retry_inc;
    logic       retry_clr;

    always_ff @(posedge clkin) begin
        if (reset) begin
            retry_cnt <= '0;
        end else if (retry_clr) begin
            retry_cnt <= '0;
        end else if (retry_inc) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`else
    // MAX_RETRY has no effect without the retry feature; only a sanity hook consumes it.
    if (MAX_RETRY < 0) begin : g_max_retry_negative
    end
`endif

    always_comb begin
        state_nxt = state;
        loss_inc  = 1'b0;
`ifdef PLL_SUP_RETRY_EN
        retry_inc = 1'b0;
        retry_clr = 1'b0;
`endif
        unique case (state)
            ST_RST_PLL: begin
                if (timer == RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                end else if (timer == TIMEOUT_LAST) begin
`ifdef PLL_SUP_RETRY_EN
                    retry_inc = 1'b1;
                    if (retry_cnt < RETRY_LIMIT) begin
                        state_nxt = ST_RST_PLL;
                    end else begin
                        state_nxt = ST_FAIL;
                    end
`else
                    state_nxt = ST_FAIL;
`endif
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                end else if (timer == STABLE_LAST) begin
                    state_nxt = ST_RUN;
`ifdef PLL_SUP_RETRY_EN
                    retry_clr = 1'b1;
`endif
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt = ST_RST_PLL;
                    loss_inc  = 1'b1;
                end
            end
            ST_FAIL: begin
                if (retry_req) begin
                    state_nxt = ST_RST_PLL;
`ifdef PLL_SUP_RETRY_EN
                    retry_clr = 1'b1;
`endif
                end
            end
            default: begin
                state_nxt = ST_RST_PLL;
            end
        endcase
    end

    // Outputs decode straight from the state register so they move with the state.
    assign pll_reset = (state == ST_RST_PLL);
    assign usb_rst   = (state != ST_RUN);
    assign ready     = (state == ST_RUN);
    assign fail      = (state == ST_FAIL);
    assign state_o   = state;

endmodule

// File: tb/tb_usb_pll_supervisor.sv
// Directed self-checking bench for usb_pll_supervisor with shortened timing parameters.
// Build with or without PLL_SUP_RETRY_EN; the timeout expectations follow the same macro.
module tb_usb_pll_supervisor;

    localparam int PLL_RST_CYC      = 4;
    localparam int LOCK_STABLE_CYC  = 16;
    localparam int LOCK_TIMEOUT_CYC = 64;
    localparam int MAX_RETRY        = 2;
    localparam int CNT_W            = 8;

`ifdef PLL_SUP_RETRY_EN
    localparam int EXP_FAIL_CYC = 3 * (PLL_RST_CYC + LOCK_TIMEOUT_CYC);
    localparam int EXP_PULSES   = 3;
`else
    localparam int EXP_FAIL_CYC = PLL_RST_CYC + LOCK_TIMEOUT_CYC;
    localparam int EXP_PULSES   = 1;
`endif

    logic             clkin;
    logic             reset;
    logic             lock;
    logic             retry_req;
    logic             pll_reset;
    logic             usb_rst;
    logic             ready;
    logic             fail;
    logic [CNT_W-1:0] loss_cnt;
    logic [2:0]       state_o;

    int n_tests = 0;
    int n_fail  = 0;

    usb_pll_supervisor #(
        .PLL_RST_CYC     (PLL_RST_CYC),
        .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
        .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
        .MAX_RETRY       (MAX_RETRY),
        .CNT_W           (CNT_W)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .lock     (lock),
        .retry_req(retry_req),
        .pll_reset(pll_reset),
        .usb_rst  (usb_rst),
        .ready    (ready),
        .fail     (fail),
        .loss_cnt (loss_cnt),
        .state_o  (state_o)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int k;
        k = 0;
        while (!ready && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, int'(ready), 1);
    endtask

    initial begin
        int prev;
        int pulses;
        int fail_n;
        int n;

        reset     = 1'b1;
        lock      = 1'b0;
        retry_req = 1'b0;
        tick(3);

        check("rst_state", int'(state_o), 0);
        check("rst_pll_reset", int'(pll_reset), 1);
        check("rst_usb_rst", int'(usb_rst), 1);
        check("rst_ready", int'(ready), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_loss", int'(loss_cnt), 0);
        reset = 1'b0;

        // 1: PLL reset pulse width
        for (int i = 0; i < PLL_RST_CYC; i++) begin
            check("s1_pll_reset_hi", int'(pll_reset), 1);
            tick(1);
        end
        check("s1_pll_reset_lo", int'(pll_reset), 0);
        check("s1_state_wait", int'(state_o), 1);
        check("s1_usb_rst", int'(usb_rst), 1);
        check("s1_ready", int'(ready), 0);

        // 2: lock 10 cycles into WAIT_LOCK, ready 19 cycles later
        tick(10);
        lock = 1'b1;
        tick(18);
        check("s2_ready_early", int'(ready), 0);
        tick(1);
        check("s2_ready", int'(ready), 1);
        check("s2_usb_rst", int'(usb_rst), 0);
        check("s2_state_run", int'(state_o), 3);
        check("s2_loss", int'(loss_cnt), 0);
        retry_req = 1'b1;
        tick(1);
        retry_req = 1'b0;
        check("s2_retry_ignored", int'(state_o), 3);

        // 4: loss of lock in RUN
        lock = 1'b0;
        tick(2);
        check("s4_ready_hold", int'(ready), 1);
        tick(1);
        check("s4_ready_drop", int'(ready), 0);
        check("s4_usb_rst", int'(usb_rst), 1);
        check("s4_loss1", int'(loss_cnt), 1);
        for (int i = 0; i < PLL_RST_CYC; i++) begin
            check("s4_pll_reset_hi", int'(pll_reset), 1);
            tick(1);
        end
        check("s4_pll_reset_lo", int'(pll_reset), 0);
        lock = 1'b1;
        tick(19);
        check("s4_relock_ready", int'(ready), 1);
        for (int k = 2; k <= 256; k++) begin
            lock = 1'b0;
            tick(3);
            check("s4_loss_sat", int'(loss_cnt), (k < 255) ? k : 255);
            lock = 1'b1;
            wait_ready("s4_relock_timeout", 100);
        end
        check("s4_loss_final", int'(loss_cnt), 255);

        // 6: one-cycle reset while in RUN
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("s6_state", int'(state_o), 0);
        check("s6_pll_reset", int'(pll_reset), 1);
        check("s6_usb_rst", int'(usb_rst), 1);
        check("s6_ready", int'(ready), 0);
        check("s6_loss", int'(loss_cnt), 0);

        // 3: lock glitch in STABLE at timer=8 (lock still high from before)
        tick(5);
        check("s3_state_stable", int'(state_o), 2);
        tick(8);
        lock = 1'b0;
        tick(2);
        check("s3_still_stable", int'(state_o), 2);
        tick(1);
        check("s3_back_wait", int'(state_o), 1);
        check("s3_ready_lo", int'(ready), 0);
        lock = 1'b1;
        tick(18);
        check("s3_ready_early", int'(ready), 0);
        tick(1);
        check("s3_ready", int'(ready), 1);
        check("s3_loss", int'(loss_cnt), 0);

        // 5: lock never arrives
        lock  = 1'b0;
        reset = 1'b1;
        tick(1);
        reset  = 1'b0;
        prev   = 0;
        pulses = 0;
        fail_n = -1;
        n      = 0;
        while (fail_n < 0 && n < 1000) begin
            if (pll_reset && prev == 0) pulses++;
            prev = int'(pll_reset);
            if (fail) fail_n = n;
            else begin
                tick(1);
                n++;
            end
        end
        check("s5_fail_cycle", fail_n, EXP_FAIL_CYC);
        check("s5_pulses", pulses, EXP_PULSES);
        tick(5);
        check("s5_fail_sticky", int'(fail), 1);
        check("s5_state_fail", int'(state_o), 4);
        retry_req = 1'b1;
        tick(1);
        retry_req = 1'b0;
        check("s5_retry_pll_reset", int'(pll_reset), 1);
        check("s5_retry_fail", int'(fail), 0);
        check("s5_retry_state", int'(state_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
